load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_store_unit_mem_align.sv | 55 +++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared processor types: execute-stage instruction, memory function codes and LSU states.
// Helper functions classify memory functions and detect misaligned accesses.
package ProcTypes;

  typedef enum logic [2:0] {Alu, Ld, St, J, Jr, Br, Auipc, Unsupported} IType;

  typedef enum logic [3:0] {NopM, Lb, Lh, Lw, Lbu, Lhu, Sb, Sh, Sw} MemFunc;

  typedef struct packed {
    IType        iType;
    MemFunc      memFunc;
    logic [4:0]  dst;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] nextPc;
  } ExecInst;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, WB} LsuState;

  function automatic logic is_load(input MemFunc f);
    return (f == Lb) || (f == Lh) || (f == Lw) || (f == Lbu) || (f == Lhu);
  endfunction

  function automatic logic is_misaligned(input MemFunc f, input logic [1:0] a);
    logic word_acc;
    logic half_acc;
    word_acc = (f == Lw) || (f == Sw);
    half_acc = (f == Lh) || (f == Lhu) || (f == Sh);
    return (word_acc && (a != 2'b00)) || (half_acc && a[0]);
  endfunction

endpackage

// File: rtl/load_store_unit_mem_align.sv
// Byte-lane handling: store data replication, strobe generation, load lane extraction/extension.
// Purely combinational; no handshake.
module mem_align
  import ProcTypes::*;
(
  input  MemFunc      mem_func,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign shifted = rd_data >> {addr_lo, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];

  always_comb begin
    wdata = '0;
    wstrb = '0;
    case (mem_func)
      Sb: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      Sh: begin
        wdata = {2{st_data[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      Sw: begin
        wdata = st_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (mem_func)
      Lb:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      Lbu:     ld_data = {24'b0, ld_byte};
      Lh:      ld_data = {{16{ld_half[15]}}, ld_half};
      Lhu:     ld_data = {16'b0, ld_half};
      Lw:      ld_data = rd_data;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one instruction in flight; request one cycle after accept, writeback one cycle after response.
// Holds request until mem_req_ready and writeback until wb_ready; loads give up after TIMEOUT_CYCLES.
module load_store_unit
  import ProcTypes::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  ExecInst     in_inst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data,
  output logic        misaligned_err,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  LsuState       state_q, state_d;
  ExecInst       inst_q, inst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          mis_err_q, mis_err_d;
  logic          to_err_q, to_err_d;

  logic [31:0]   al_wdata;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_ld_data;
  logic          unused_fields;

  assign unused_fields = ^{inst_q.iType, inst_q.nextPc};

  mem_align u_mem_align (
    .mem_func (inst_q.memFunc),
    .addr_lo  (inst_q.addr[1:0]),
    .st_data  (inst_q.data),
    .rd_data  (mem_resp_rdata),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .ld_data  (al_ld_data)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    mis_err_d = 1'b0;
    to_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          inst_d = in_inst;
          if (is_misaligned(in_inst.memFunc, in_inst.addr[1:0])) begin
            mis_err_d = 1'b1;
          end else if (in_inst.memFunc == NopM) begin
            wb_data_d = in_inst.data;
            state_d   = WB;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          if (is_load(inst_q.memFunc)) begin
            cnt_d   = '0;
            state_d = WAIT_RESP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_RESP: begin
        // A response on the last counted cycle still wins over the timeout.
        if (mem_resp_valid) begin
          wb_data_d = al_ld_data;
          state_d   = WB;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      mis_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      mis_err_q <= mis_err_d;
      to_err_q  <= to_err_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_addr   = mem_req_valid ? {inst_q.addr[31:2], 2'b00} : '0;
  assign mem_req_we     = mem_req_valid && !is_load(inst_q.memFunc);
  assign mem_req_wdata  = mem_req_valid ? al_wdata : '0;
  assign mem_req_wstrb  = mem_req_valid ? al_wstrb : '0;
  assign wb_valid       = (state_q == WB);
  assign wb_dst         = wb_valid ? inst_q.dst : '0;
  assign wb_data        = wb_valid ? wb_data_q : '0;
  assign misaligned_err = mis_err_q;
  assign timeout_err    = to_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for single accesses plus
// sequences for backpressure, timeout and mid-transaction reset.
module tb_load_store_unit;
  import ProcTypes::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  ExecInst     in_inst = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        misaligned_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  localparam int K_NOP = 0, K_LD = 1, K_ST = 2, K_MIS = 3;

  typedef struct {
    MemFunc      f;
    logic [4:0]  dst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          kind;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[12];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_dst         (wb_dst),
    .wb_data        (wb_data),
    .misaligned_err (misaligned_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents the instruction for one rising edge, returns at the next negedge.
  task automatic send(input MemFunc f, input logic [4:0] dst, input logic [31:0] addr,
                      input logic [31:0] data);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_inst         = '0;
    in_inst.memFunc = f;
    in_inst.dst     = dst;
    in_inst.addr    = addr;
    in_inst.data    = data;
    in_inst.nextPc  = addr + 32'd4;
    in_valid        = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_inst  = '0;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{Sb,   5'd1,  32'h0000_1003, 32'h0000_00A5, 32'h0,         K_ST,  32'hA5A5_A5A5, 4'b1000, 32'h0};
    vecs[1]  = '{Sh,   5'd2,  32'h0000_0002, 32'h1234_BEEF, 32'h0,         K_ST,  32'hBEEF_BEEF, 4'b1100, 32'h0};
    vecs[2]  = '{Sw,   5'd3,  32'h0000_4000, 32'hDEAD_BEEF, 32'h0,         K_ST,  32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[3]  = '{Lh,   5'd4,  32'h0000_2002, 32'h0,         32'h8001_1234, K_LD,  32'h0,         4'b0000, 32'hFFFF_8001};
    vecs[4]  = '{Lhu,  5'd5,  32'h0000_2002, 32'h0,         32'h8001_1234, K_LD,  32'h0,         4'b0000, 32'h0000_8001};
    vecs[5]  = '{Lb,   5'd6,  32'h0000_5001, 32'h0,         32'h1234_8056, K_LD,  32'h0,         4'b0000, 32'hFFFF_FF80};
    vecs[6]  = '{Lbu,  5'd7,  32'h0000_5003, 32'h0,         32'hF100_0000, K_LD,  32'h0,         4'b0000, 32'h0000_00F1};
    vecs[7]  = '{Lw,   5'd8,  32'h0000_3001, 32'h0,         32'h0,         K_MIS, 32'h0,         4'b0000, 32'h0};
    vecs[8]  = '{Sh,   5'd9,  32'h0000_0001, 32'h0000_1111, 32'h0,         K_MIS, 32'h0,         4'b0000, 32'h0};
    vecs[9]  = '{NopM, 5'd10, 32'h0,         32'h00C0_FFEE, 32'h0,         K_NOP, 32'h0,         4'b0000, 32'h00C0_FFEE};
    vecs[10] = '{Lw,   5'd0,  32'h0000_6000, 32'h0,         32'h89AB_CDEF, K_LD,  32'h0,         4'b0000, 32'h89AB_CDEF};
    vecs[11] = '{Sb,   5'd11, 32'h0000_0021, 32'h0000_003C, 32'h0,         K_ST,  32'h3C3C_3C3C, 4'b0010, 32'h0};

    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_misaligned_err", 32'(misaligned_err), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      send(v.f, v.dst, v.addr, v.data);
      case (v.kind)
        K_MIS: begin
          chk($sformatf("v%0d_mis_pulse", i), 32'(misaligned_err), 32'd1);
          chk($sformatf("v%0d_mis_no_req", i), 32'(mem_req_valid), 32'd0);
          chk($sformatf("v%0d_mis_in_ready", i), 32'(in_ready), 32'd1);
          @(negedge clk);
          chk($sformatf("v%0d_mis_pulse_end", i), 32'(misaligned_err), 32'd0);
          chk($sformatf("v%0d_mis_no_req2", i), 32'(mem_req_valid), 32'd0);
          chk($sformatf("v%0d_mis_no_wb", i), 32'(wb_valid), 32'd0);
        end
        K_ST: begin
          chk($sformatf("v%0d_st_req_valid", i), 32'(mem_req_valid), 32'd1);
          chk($sformatf("v%0d_st_we", i), 32'(mem_req_we), 32'd1);
          chk($sformatf("v%0d_st_addr", i), mem_req_addr, v.addr & 32'hFFFF_FFFC);
          chk($sformatf("v%0d_st_wdata", i), mem_req_wdata, v.exp_wdata);
          chk($sformatf("v%0d_st_wstrb", i), 32'(mem_req_wstrb), 32'(v.exp_wstrb));
          chk($sformatf("v%0d_st_no_wb", i), 32'(wb_valid), 32'd0);
          @(negedge clk);
          chk($sformatf("v%0d_st_done", i), 32'(mem_req_valid), 32'd0);
          chk($sformatf("v%0d_st_no_wb2", i), 32'(wb_valid), 32'd0);
          chk($sformatf("v%0d_st_idle", i), 32'(in_ready), 32'd1);
        end
        K_LD: begin
          chk($sformatf("v%0d_ld_req_valid", i), 32'(mem_req_valid), 32'd1);
          chk($sformatf("v%0d_ld_we", i), 32'(mem_req_we), 32'd0);
          chk($sformatf("v%0d_ld_addr", i), mem_req_addr, v.addr & 32'hFFFF_FFFC);
          @(negedge clk);
          mem_resp_valid = 1'b1;
          mem_resp_rdata = v.rdata;
          @(negedge clk);
          mem_resp_valid = 1'b0;
          mem_resp_rdata = '0;
          chk($sformatf("v%0d_ld_wb_valid", i), 32'(wb_valid), 32'd1);
          chk($sformatf("v%0d_ld_wb_data", i), wb_data, v.exp_wb);
          chk($sformatf("v%0d_ld_wb_dst", i), 32'(wb_dst), 32'(v.dst));
          @(negedge clk);
          chk($sformatf("v%0d_ld_wb_done", i), 32'(wb_valid), 32'd0);
        end
        default: begin
          chk($sformatf("v%0d_nop_wb_valid", i), 32'(wb_valid), 32'd1);
          chk($sformatf("v%0d_nop_wb_data", i), wb_data, v.exp_wb);
          chk($sformatf("v%0d_nop_wb_dst", i), 32'(wb_dst), 32'(v.dst));
          chk($sformatf("v%0d_nop_no_req", i), 32'(mem_req_valid), 32'd0);
          @(negedge clk);
          chk($sformatf("v%0d_nop_wb_done", i), 32'(wb_valid), 32'd0);
        end
      endcase
    end

    // Request backpressure for 5 cycles, then writeback backpressure
    mem_req_ready = 1'b0;
    wb_ready      = 1'b0;
    send(Lw, 5'd12, 32'h0000_7004, 32'h0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_req_valid_c%0d", c), 32'(mem_req_valid), 32'd1);
      chk($sformatf("bp_req_addr_c%0d", c), mem_req_addr, 32'h0000_7004);
      chk($sformatf("bp_req_we_c%0d", c), 32'(mem_req_we), 32'd0);
      if (c == 4) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    chk("bp_req_dropped", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    mem_req_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_wb_valid_c%0d", c), 32'(wb_valid), 32'd1);
      chk($sformatf("bp_wb_data_c%0d", c), wb_data, 32'h1122_3344);
      chk($sformatf("bp_wb_dst_c%0d", c), 32'(wb_dst), 32'd12);
      if (c == 3) wb_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_wb_released", 32'(wb_valid), 32'd0);
    chk("bp_idle", 32'(in_ready), 32'd1);

    // Load timeout: no response, TIMEOUT_CYCLES=4
    send(Lw, 5'd13, 32'h0000_8000, 32'h0);
    chk("to_req_valid", 32'(mem_req_valid), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("to_wait_no_err_c%0d", c), 32'(timeout_err), 32'd0);
      chk($sformatf("to_wait_no_wb_c%0d", c), 32'(wb_valid), 32'd0);
      chk($sformatf("to_wait_busy_c%0d", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_idle", 32'(in_ready), 32'd1);
    chk("to_no_wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_no_wb2", 32'(wb_valid), 32'd0);

    // Reset asserted while waiting for a load response
    send(Lw, 5'd14, 32'h0000_9000, 32'h0);
    @(negedge clk);
    chk("rr_in_wait", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    chk("rr_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rr_req_addr", mem_req_addr, 32'd0);
    chk("rr_wb_valid", 32'(wb_valid), 32'd0);
    chk("rr_wb_data", wb_data, 32'd0);
    chk("rr_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rr_late_resp_no_wb", 32'(wb_valid), 32'd0);
    chk("rr_late_resp_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rr_late_resp_no_wb2", 32'(wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
